// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the LC-3b pipeline. It captures the decoded
// operands, the control bundle and the register specifiers from ID. It detects
// load-use hazards, holds IF/ID for one cycle, and inserts a single bubble. It
// also selects the final EX operands from the forwarding unit's selects.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   id_valid               ID holds a real instruction
//   id_src1/id_src2/id_dest register specifiers from ID (3 bits)
//   id_uses_src2           ID instruction actually reads src2
//   id_regwrite/id_memread ID instruction writes a register / is a load
//   id_sr1_data/id_sr2_data regfile read data (16 bits)
//   id_pc, id_ctrl         PC and opaque EX/MEM/WB control bundle
//   mem_stall              global freeze; every register holds
//   flush                  squash the instruction entering ID/EX
//   ForwardA/ForwardB      operand selects: 10 = EX/MEM, 01 = MEM/WB, else reg
//   exmem_alu_out          EX/MEM forwarding source
//   memwb_wb_data          MEM/WB forwarding source
//   src1_idex/src2_idex/dest_idex registered specifiers for forwarding_unit
//   idex_regwrite/idex_memread    registered, 0 for bubbles
//   ex_valid, ex_opA, ex_opB, ex_pc, ex_ctrl  EX-side outputs
//   stall_if_id            hold PC and IF/ID this cycle
//   lu_stall_count         saturating count of load-use bubbles
//
// Flow semantics: an instruction moves from ID into ID/EX on every rising
// edge unless mem_stall is high (everything holds) or a bubble is forced by
// flush or a load-use hazard. ex_valid marks a real instruction in EX, and
// stall_if_id tells the front end that the ID instruction was not consumed.
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [2:0]        id_src1,
    input  logic [2:0]        id_src2,
    input  logic [2:0]        id_dest,
    input  logic              id_uses_src2,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [15:0]       id_sr1_data,
    input  logic [15:0]       id_sr2_data,
    input  logic [15:0]       id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              mem_stall,
    input  logic              flush,
    input  logic [1:0]        ForwardA,
    input  logic [1:0]        ForwardB,
    input  logic [15:0]       exmem_alu_out,
    input  logic [15:0]       memwb_wb_data,
    output logic [2:0]        src1_idex,
    output logic [2:0]        src2_idex,
    output logic [2:0]        dest_idex,
    output logic              idex_regwrite,
    output logic              idex_memread,
    output logic              ex_valid,
    output logic [15:0]       ex_opA,
    output logic [15:0]       ex_opB,
    output logic [15:0]       ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_if_id,
    output logic [15:0]       lu_stall_count
);

    logic [15:0] sr1_q;
    logic [15:0] sr2_q;
    logic        lu_hazard;

    // R0 is compared like any other register: a load into R0 still stalls.
    always_comb begin
        lu_hazard = id_valid & ex_valid & idex_memread &
                    ((id_src1 == dest_idex) |
                     (id_uses_src2 & (id_src2 == dest_idex)));
    end

    // During mem_stall the top level freezes IF/ID itself. During flush the
    // fetch redirect must go ahead, so no stall is requested in either case.
    assign stall_if_id = lu_hazard & ~flush & ~mem_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid       <= 1'b0;
            idex_regwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            ex_ctrl        <= '0;
            src1_idex      <= 3'd0;
            src2_idex      <= 3'd0;
            dest_idex      <= 3'd0;
            ex_pc          <= 16'd0;
            sr1_q          <= 16'd0;
            sr2_q          <= 16'd0;
            lu_stall_count <= 16'd0;
        end else if (!mem_stall) begin
            if (flush || lu_hazard) begin
                // Bubble: only the qualifiers are cleared; specifiers, data
                // and PC keep stale values that nothing downstream trusts.
                ex_valid      <= 1'b0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
                ex_ctrl       <= '0;
                // A flush already squashes the consumer, so the bubble it
                // causes is not charged to the load-use counter.
                if (!flush && lu_stall_count != 16'hFFFF) begin
                    lu_stall_count <= lu_stall_count + 16'd1;
                end
            end else begin
                ex_valid      <= id_valid;
                idex_regwrite <= id_valid & id_regwrite;
                idex_memread  <= id_valid & id_memread;
                ex_ctrl       <= id_valid ? id_ctrl : '0;
                src1_idex     <= id_src1;
                src2_idex     <= id_src2;
                dest_idex     <= id_dest;
                ex_pc         <= id_pc;
                sr1_q         <= id_sr1_data;
                sr2_q         <= id_sr2_data;
            end
        end
    end

    // Select 2'b11 is not produced by forwarding_unit; it falls back to the
    // registered operand like 2'b00.
    always_comb begin
        ex_opA = sr1_q;
        ex_opB = sr2_q;
        case (ForwardA)
            2'b10:   ex_opA = exmem_alu_out;
            2'b01:   ex_opA = memwb_wb_data;
            default: ex_opA = sr1_q;
        endcase
        case (ForwardB)
            2'b10:   ex_opB = exmem_alu_out;
            2'b01:   ex_opB = memwb_wb_data;
            default: ex_opB = sr2_q;
        endcase
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the LC-3b pipeline, sitting between decode and execute. It captures decoded operands, control and register specifiers from ID. It detects load-use hazards, stalls IF/ID, and inserts bubbles. It presents `src1_idex`/`src2_idex` to `forwarding_unit` and consumes its `ForwardA`/`ForwardB` selects to drive the final EX operands.

## Interface
- `CTRL_W`, default 16: width of the opaque EX/MEM/WB control bundle carried through the stage.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `id_valid`  in  1  ID holds a real instruction.
- `id_src1`, `id_src2`  in  lc3b_reg  source register numbers.
- `id_dest`  in  lc3b_reg  destination register number.
- `id_uses_src2`  in  1  instruction reads `src2` (register-mode ALU op, STR data).
- `id_regwrite`  in  1  instruction writes `id_dest`.
- `id_memread`  in  1  instruction is a load (LDR/LDB/LDI).
- `id_sr1_data`, `id_sr2_data`  in  lc3b_word  regfile read data.
- `id_pc`  in  lc3b_word  PC of the ID instruction.
- `id_ctrl`  in  `CTRL_W`  control bundle.
- `mem_stall`  in  1  global freeze (cache miss); hold all state.
- `flush`  in  1  taken branch/jump resolved downstream; squash the instruction entering ID/EX.
- `ForwardA`, `ForwardB`  in  lc3b_2bit  selects from `forwarding_unit`.
- `exmem_alu_out`  in  lc3b_word  EX/MEM result (select 2'b10).
- `memwb_wb_data`  in  lc3b_word  MEM/WB writeback value (select 2'b01).
- `src1_idex`, `src2_idex`, `dest_idex`  out  lc3b_reg  registered specifiers.
- `idex_regwrite`, `idex_memread`  out  1  registered, forced 0 for bubbles.
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_opA`, `ex_opB`  out  lc3b_word  forwarded operands.
- `ex_pc`  out  lc3b_word; `ex_ctrl`  out  `CTRL_W`.
- `stall_if_id`  out  1  hold PC and IF/ID this cycle.
- `lu_stall_count`  out  16  saturating count of load-use bubbles.

## Operation
- **Load-use detect (combinational):** `lu_hazard = id_valid & ex_valid & idex_memread & ((id_src1 == dest_idex) | (id_uses_src2 & (id_src2 == dest_idex)))`. The comparison includes R0.
- `stall_if_id = lu_hazard & ~flush & ~mem_stall`.
- **Per-edge update priority**, highest first:
  - `mem_stall`: hold every register, including the counter.
  - `flush`: load a bubble.
  - `lu_hazard`: load a bubble and increment the counter.
  - Otherwise: capture all `id_*` inputs.
- **Bubble:** `ex_valid`, `idex_regwrite` and `idex_memread` are 0, and `ex_ctrl` is all zeros. The specifier, data and PC registers may hold any value, but their values are don't-care.
- **Operand mux (combinational):**
  - `ex_opA` is `exmem_alu_out` when `ForwardA`=2'b10, `memwb_wb_data` when 2'b01, and registered `sr1` otherwise (including 2'b11).
  - `ex_opB` is selected the same way from `ForwardB` and registered `sr2`.
- **Counter:** `lu_stall_count` saturates at 16'hFFFF and does not wrap.
- A captured instruction with `id_valid`=0 is itself a bubble: `idex_regwrite` and `idex_memread` are gated by `id_valid`.

## Timing
- Reset values: `ex_valid`, `idex_regwrite`, `idex_memread`, `ex_ctrl`, `src1_idex`, `src2_idex`, `dest_idex`, `ex_pc`, registered `sr1`/`sr2` and `lu_stall_count` are all 0. `stall_if_id` is therefore 0. `ex_opA`/`ex_opB` follow the mux.
- Latency: ID to EX is 1 cycle.
- A load-use pair costs exactly one bubble:
  - Cycle N: the load is in ID/EX, and `stall_if_id`=1.
  - Cycle N+1: a bubble is in ID/EX, the load is in EX/MEM, and `lu_hazard` evaluates 0.
  - Cycle N+2: the consumer is in ID/EX, and `forwarding_unit` selects 2'b01.
- `mem_stall` asserted for k cycles extends any state, including a pending bubble, by exactly k cycles. `stall_if_id` is 0 while `mem_stall`=1, because the top level freezes IF/ID itself.
- `flush` together with `lu_hazard`: the bubble is taken and the counter is not incremented. `stall_if_id` is 0 so the fetch redirect proceeds.
- Reset mid-stall: outputs clear asynchronously and the stage restarts empty on release.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with `ex_valid`=1 -> all registered outputs 0 immediately, `lu_stall_count`=0.
- **Plain flow:** `ADD R1,R2,R3` with sr1=16'h0005, sr2=16'h0003, Forward=00 -> next cycle `ex_valid`=1, `ex_opA`=5, `ex_opB`=3, `src1_idex`=2, `src2_idex`=3, `dest_idex`=1.
- **Load-use:** `LDR R4` in ID/EX, `ADD R5,R4,R6` in ID -> `stall_if_id`=1 for one cycle. The next cycle shows a bubble with `ex_valid`=0 and `lu_stall_count`=1. The ADD enters on the following cycle, and `ForwardA`=01 with `memwb_wb_data`=16'hBEEF gives `ex_opA`=16'hBEEF.
- **src2 gating:** `LDR R4` in ID/EX, ID instruction has src2=4 but `id_uses_src2`=0 and src1≠4 -> no stall.
- **Forward muxing:** registered sr1=1, sr2=2; apply `ForwardA`/`ForwardB` = 10, 01, 11 with `exmem_alu_out`=16'h1111 and `memwb_wb_data`=16'h2222 -> operands 1111, 2222, then registered (1/2).
- **Stall/flush interplay:** `mem_stall` held 3 cycles during a load-use hazard -> state frozen, `stall_if_id`=0, one bubble after release. Then `flush` plus hazard in the same cycle -> bubble, counter unchanged. Preload the counter to 16'hFFFF via repeated hazards -> it stays at FFFF.
